// File: rtl/jesd204_rx_sync_ctrl.sv
// jesd204_rx_sync_ctrl
//   Link-level sequencer for the JESD204 receive path. It releases the
//   per-lane CGS blocks and aggregates their ready flags. It drives SYNC~
//   low to request code group synchronisation, and raises it on an LMFC
//   boundary once every enabled lane is ready. Any loss of an enabled lane
//   re-enters CGS and bumps a saturating resync counter.
//
// Ports
//   clk, reset          link clock, asynchronous active-high reset
//   cfg_enable          link enable (0 forces RESET)
//   cfg_lanes_disable   per-lane exclusion mask (1 = lane ignored)
//   phy_ready           transceiver ready
//   cgs_ready           per-lane ready from jesd204_rx_cgs
//   lmfc_edge           single-cycle LMFC boundary pulse
//   cgs_reset           per-lane CGS reset (1 = held in reset)
//   ifs_reset           per-lane ILAS/frame-alignment reset
//   sync                SYNC~ (active-low CGS request)
//   link_up             high in SYNCHRONIZED
//   state               0 RESET, 1 WAIT_PHY, 2 CGS, 3 SYNCHRONIZED
//   resync_count        saturating count of sync losses
module jesd204_rx_sync_ctrl #(
  parameter int NUM_LANES       = 4,
  parameter int PHY_GOOD_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_enable,
  input  logic [NUM_LANES-1:0] cfg_lanes_disable,
  input  logic                 phy_ready,
  input  logic [NUM_LANES-1:0] cgs_ready,
  input  logic                 lmfc_edge,
  output logic [NUM_LANES-1:0] cgs_reset,
  output logic [NUM_LANES-1:0] ifs_reset,
  output logic                 sync,
  output logic                 link_up,
  output logic [1:0]           state,
  output logic [7:0]           resync_count
);

  typedef enum logic [1:0] {
    ST_RESET    = 2'd0,
    ST_WAIT_PHY = 2'd1,
    ST_CGS      = 2'd2,
    ST_SYNC     = 2'd3
  } state_t;

  // The transition fires on the edge where the count would reach
  // PHY_GOOD_CYCLES, so a stable phy_ready reaches CGS in exactly
  // PHY_GOOD_CYCLES edges.
  localparam logic [7:0] PHY_LAST = 8'(PHY_GOOD_CYCLES - 1);

  state_t               state_q, state_d;
  logic [7:0]           phy_cnt_q, phy_cnt_d;
  logic [7:0]           resync_q, resync_d;
  logic                 sync_q, sync_d;
  logic                 link_up_q, link_up_d;
  logic [NUM_LANES-1:0] cgs_reset_q, cgs_reset_d;
  logic [NUM_LANES-1:0] ifs_reset_q, ifs_reset_d;

  logic [NUM_LANES-1:0] en_mask;
  logic                 all_ready;
  logic                 lane_lost;
  logic                 link_allowed;

  always_comb begin
    en_mask      = ~cfg_lanes_disable;
    all_ready    = &(cgs_ready | cfg_lanes_disable);
    lane_lost    = |(en_mask & ~cgs_ready);
    link_allowed = cfg_enable & (|en_mask);
  end

  always_comb begin
    state_d   = state_q;
    phy_cnt_d = '0;
    resync_d  = resync_q;

    if (!link_allowed) begin
      state_d = ST_RESET;
    end else begin
      case (state_q)
        ST_RESET: state_d = ST_WAIT_PHY;
        ST_WAIT_PHY: begin
          if (phy_ready) begin
            if (phy_cnt_q == PHY_LAST) state_d = ST_CGS;
            else                       phy_cnt_d = phy_cnt_q + 8'd1;
          end
        end
        ST_CGS: begin
          if (!phy_ready)                  state_d = ST_WAIT_PHY;
          else if (all_ready && lmfc_edge) state_d = ST_SYNC;
        end
        ST_SYNC: begin
          if (!phy_ready) begin
            state_d = ST_WAIT_PHY;
          end else if (lane_lost) begin
            state_d = ST_CGS;
            if (resync_q != 8'hFF) resync_d = resync_q + 8'd1;
          end
        end
        default: state_d = ST_RESET;
      endcase
    end

    // Outputs are decoded from the next state so they register on the same
    // edge as the state itself.
    sync_d      = (state_d != ST_CGS);
    link_up_d   = (state_d == ST_SYNC);
    cgs_reset_d = (state_d == ST_CGS || state_d == ST_SYNC) ? cfg_lanes_disable : '1;
    ifs_reset_d = (state_d == ST_SYNC) ? cfg_lanes_disable : '1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RESET;
      phy_cnt_q   <= '0;
      resync_q    <= '0;
      sync_q      <= 1'b1;
      link_up_q   <= 1'b0;
      cgs_reset_q <= '1;
      ifs_reset_q <= '1;
    end else begin
      state_q     <= state_d;
      phy_cnt_q   <= phy_cnt_d;
      resync_q    <= resync_d;
      sync_q      <= sync_d;
      link_up_q   <= link_up_d;
      cgs_reset_q <= cgs_reset_d;
      ifs_reset_q <= ifs_reset_d;
    end
  end

  assign state        = state_q;
  assign resync_count = resync_q;
  assign sync         = sync_q;
  assign link_up      = link_up_q;
  assign cgs_reset    = cgs_reset_q;
  assign ifs_reset    = ifs_reset_q;

endmodule

// File: tb/tb_jesd204_rx_sync_ctrl.sv
module tb_jesd204_rx_sync_ctrl;

  localparam int NL = 4;

  logic          clk;
  logic          reset;
  logic          cfg_enable;
  logic [NL-1:0] cfg_lanes_disable;
  logic          phy_ready;
  logic [NL-1:0] cgs_ready;
  logic          lmfc_edge;
  logic [NL-1:0] cgs_reset;
  logic [NL-1:0] ifs_reset;
  logic          sync;
  logic          link_up;
  logic [1:0]    state;
  logic [7:0]    resync_count;

  jesd204_rx_sync_ctrl #(.NUM_LANES(NL), .PHY_GOOD_CYCLES(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .cfg_enable       (cfg_enable),
    .cfg_lanes_disable(cfg_lanes_disable),
    .phy_ready        (phy_ready),
    .cgs_ready        (cgs_ready),
    .lmfc_edge        (lmfc_edge),
    .cgs_reset        (cgs_reset),
    .ifs_reset        (ifs_reset),
    .sync             (sync),
    .link_up          (link_up),
    .state            (state),
    .resync_count     (resync_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    logic [1:0]    st;
    logic          sy;
    logic          lu;
    logic [NL-1:0] cr;
    logic [NL-1:0] ir;
    logic [7:0]    rc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Expected outputs follow the documented decode of the expected state,
  // using the lane mask presented at the edge.
  task automatic push(input string tag, input logic [1:0] st, input logic [7:0] rc);
    exp_t e;
    e.tag = tag;
    e.st  = st;
    e.sy  = (st != 2'd2);
    e.lu  = (st == 2'd3);
    e.cr  = (st >= 2'd2) ? cfg_lanes_disable : '1;
    e.ir  = (st == 2'd3) ? cfg_lanes_disable : '1;
    e.rc  = rc;
    q.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    e = q.pop_front();
    checks++;
    assert (state === e.st) else begin
      errors++; $error("FAIL %s.state got %0d exp %0d", e.tag, state, e.st);
    end
    checks++;
    assert (sync === e.sy) else begin
      errors++; $error("FAIL %s.sync got %0b exp %0b", e.tag, sync, e.sy);
    end
    checks++;
    assert (link_up === e.lu) else begin
      errors++; $error("FAIL %s.link_up got %0b exp %0b", e.tag, link_up, e.lu);
    end
    checks++;
    assert (cgs_reset === e.cr) else begin
      errors++; $error("FAIL %s.cgs_reset got %b exp %b", e.tag, cgs_reset, e.cr);
    end
    checks++;
    assert (ifs_reset === e.ir) else begin
      errors++; $error("FAIL %s.ifs_reset got %b exp %b", e.tag, ifs_reset, e.ir);
    end
    checks++;
    assert (resync_count === e.rc) else begin
      errors++; $error("FAIL %s.resync got %0d exp %0d", e.tag, resync_count, e.rc);
    end
  endtask

  // Called 1 time unit after a rising edge; drives lmfc for the next edge.
  task automatic step(input logic lmfc, input logic [1:0] st, input logic [7:0] rc,
                      input string tag);
    lmfc_edge = lmfc;
    push(tag, st, rc);
    @(posedge clk);
    #1;
    lmfc_edge = 1'b0;
    compare();
  endtask

  task automatic check_now(input string tag, input logic [1:0] st, input logic [7:0] rc);
    push(tag, st, rc);
    compare();
  endtask

  // Bring-up from RESET with all inputs already set: 1 edge to WAIT_PHY,
  // then four qualified phy cycles to CGS.
  task automatic bring_to_cgs(input logic [7:0] rc, input logic lmfc_last, input string tag);
    step(1'b0, 2'd1, rc, {tag, "_wait"});
    for (int i = 0; i < 3; i++) step(1'b0, 2'd1, rc, {tag, "_cnt"});
    step(lmfc_last, 2'd2, rc, {tag, "_cgs"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rc;

    reset = 1'b1;
    cfg_enable = 1'b0;
    cfg_lanes_disable = '0;
    phy_ready = 1'b0;
    cgs_ready = '0;
    lmfc_edge = 1'b0;
    #2;
    check_now("reset", 2'd0, 8'd0);
    #10 reset = 1'b0;
    @(posedge clk);
    #1;
    step(1'b0, 2'd0, 8'd0, "idle");

    // Bring-up: CGS entered five edges after enable; lanes not yet ready.
    phy_ready = 1'b1;
    cfg_enable = 1'b1;
    bring_to_cgs(8'd0, 1'b0, "bringup");
    step(1'b1, 2'd2, 8'd0, "lmfc_notready");
    cgs_ready = '1;
    step(1'b0, 2'd2, 8'd0, "ready_nolmfc");
    step(1'b0, 2'd2, 8'd0, "ready_nolmfc2");
    step(1'b1, 2'd3, 8'd0, "synced");
    step(1'b0, 2'd3, 8'd0, "synced_hold");

    // Lane loss, then resync on the next qualifying LMFC edge.
    cgs_ready[2] = 1'b0;
    step(1'b0, 2'd2, 8'd1, "loss");
    cgs_ready[2] = 1'b1;
    step(1'b0, 2'd2, 8'd1, "loss_wait");
    step(1'b1, 2'd3, 8'd1, "resync");

    // Lane loss coincident with LMFC: loss wins.
    cgs_ready[1] = 1'b0;
    step(1'b1, 2'd2, 8'd2, "loss_lmfc");
    cgs_ready[1] = 1'b1;
    step(1'b1, 2'd3, 8'd2, "resync2");

    // Enable drop keeps the counter.
    cfg_enable = 1'b0;
    step(1'b0, 2'd0, 8'd2, "en_drop");
    step(1'b0, 2'd0, 8'd2, "en_low");

    // Disabled lane; all_ready on the CGS-entry edge is ignored.
    cfg_lanes_disable = 4'b0100;
    cgs_ready = 4'b1011;
    cfg_enable = 1'b1;
    bring_to_cgs(8'd2, 1'b1, "dis");
    step(1'b0, 2'd2, 8'd2, "dis_wait");
    step(1'b1, 2'd3, 8'd2, "dis_sync");
    for (int i = 0; i < 4; i++) begin
      cgs_ready[2] = ~cgs_ready[2];
      step(1'b0, 2'd3, 8'd2, "dis_toggle");
    end

    // All lanes disabled holds RESET.
    cfg_lanes_disable = 4'b1111;
    step(1'b0, 2'd0, 8'd2, "all_dis");
    step(1'b0, 2'd0, 8'd2, "all_dis_hold");

    // PHY drop in SYNCHRONIZED.
    cfg_lanes_disable = '0;
    cgs_ready = '1;
    bring_to_cgs(8'd2, 1'b0, "phy");
    step(1'b1, 2'd3, 8'd2, "phy_sync");
    phy_ready = 1'b0;
    step(1'b0, 2'd1, 8'd2, "phy_drop");

    // Debounce: 3 high, 1 low, then 4 high.
    phy_ready = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 2'd1, 8'd2, "deb_run3");
    phy_ready = 1'b0;
    step(1'b0, 2'd1, 8'd2, "deb_low");
    phy_ready = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 2'd1, 8'd2, "deb_run4");
    step(1'b0, 2'd2, 8'd2, "deb_cgs");
    step(1'b1, 2'd3, 8'd2, "deb_sync");

    // 300 lane-loss events saturate the counter at 255.
    rc = 8'd2;
    for (int i = 0; i < 300; i++) begin
      if (rc != 8'd255) rc = rc + 8'd1;
      cgs_ready[i % NL] = 1'b0;
      step(1'b0, 2'd2, rc, "sat_loss");
      cgs_ready = '1;
      step(1'b1, 2'd3, rc, "sat_resync");
    end
    checks++;
    assert (rc === 8'd255) else begin
      errors++; $error("FAIL sat_model got %0d exp 255", rc);
    end

    // Async reset mid-CGS, between clock edges.
    cgs_ready[3] = 1'b0;
    step(1'b0, 2'd2, 8'd255, "pre_areset");
    cgs_ready[3] = 1'b1;
    #2 reset = 1'b1;
    #1;
    check_now("areset", 2'd0, 8'd0);
    step(1'b0, 2'd0, 8'd0, "areset_hold");
    reset = 1'b0;
    step(1'b0, 2'd1, 8'd0, "post_reset");

    checks++;
    assert (q.size() === 0) else begin
      errors++; $error("FAIL queue_left got %0d exp 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
